// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_LIMIT_DEF = 255;

  // Words need a 4-byte aligned address, halfwords a 2-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_W:        return a != 2'b00;
      F3_H, F3_HU: return a[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus with req/gnt/rvalid handshake; master is the LSU, slave the memory.
interface mem_access_unit_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_gnt, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_gnt, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_format.sv
// Extracts the addressed byte/halfword from a read word and extends it.
module load_format
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign or zero extension.
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      F3_W:    data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per access, stalls the
// pipeline until the response, returns formatted load data in DONE.
//
//   state  | meaning
//   IDLE   | no access in flight; request issued combinationally on access
//   REQ    | request presented, waiting for dbus_gnt
//   WAIT   | granted, waiting for dbus_rvalid (read data or write ack)
//   DONE   | result valid for one cycle, stall released
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [2:0]        Funct3_M,
  input  logic [31:0]       MemAddr_M,
  input  logic [31:0]       MemWriteData_M,
  output logic [31:0]       MemReadData_M,
  output logic              stall_M,
  output logic              misalign_M,
  output logic              bus_err_M,
  mem_access_unit_if.master dbus
);

  localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      fmt_data;

  logic mem_op, misaligned, access, timeout;
  logic req_raw, stall_raw, capture_rd, set_err;

  assign mem_op     = MemRead_M | MemWrite_M;
  assign misaligned = is_misaligned(Funct3_M, MemAddr_M[1:0]);
  assign access     = mem_op & ~misaligned;
  assign timeout    = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; rvalid beats a coincident timeout.
  always_comb begin
    state_d    = state_q;
    req_raw    = 1'b0;
    stall_raw  = 1'b0;
    capture_rd = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_raw   = access;
        stall_raw = access;
        if (access) state_d = dbus.dbus_gnt ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (timeout) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end else if (dbus.dbus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_raw = 1'b1;
        if (dbus.dbus_rvalid) begin
          capture_rd = 1'b1;
          state_d    = S_DONE;
        end else if (timeout) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request attributes, timeout counter and captured response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      err_q <= set_err;
      if (state_q == S_REQ || state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                                       cnt_q <= '0;
      if (state_q == S_IDLE && access) begin
        f3_q  <= Funct3_M;
        off_q <= MemAddr_M[1:0];
        we_q  <= MemWrite_M;
      end
      if (capture_rd)   rdata_q <= dbus.dbus_rdata;
      else if (set_err) rdata_q <= 32'h0000_0000;
    end
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    dbus.dbus_wdata = MemWriteData_M;
    dbus.dbus_be    = 4'b1111;
    if (MemWrite_M) begin
      case (Funct3_M[1:0])
        2'b00: begin
          dbus.dbus_wdata = {4{MemWriteData_M[7:0]}};
          dbus.dbus_be    = 4'b0001 << MemAddr_M[1:0];
        end
        2'b01: begin
          dbus.dbus_wdata = {2{MemWriteData_M[15:0]}};
          dbus.dbus_be    = 4'b0011 << MemAddr_M[1:0];
        end
        default: ;
      endcase
    end
  end

  load_format u_load_format (
    .word   (rdata_q),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (fmt_data)
  );

  // Gating with reset drops the request and stall in the same cycle reset rises.
  assign dbus.dbus_req  = req_raw & ~reset;
  assign stall_M        = stall_raw & ~reset;
  assign dbus.dbus_we   = MemWrite_M;
  assign dbus.dbus_addr = {MemAddr_M[31:2], 2'b00};
  assign misalign_M     = (state_q == S_IDLE) & mem_op & misaligned;
  assign bus_err_M      = err_q & (state_q == S_DONE);
  assign MemReadData_M  = (state_q == S_DONE && !we_q) ? fmt_data : 32'h0000_0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-limit instance for the main
// traffic, a WAIT_LIMIT=4 instance for timeout behaviour.
module tb_mem_access_unit;
  import lsu_pkg::*;

  logic        clk, reset;
  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  logic [31:0] rdata_m;
  logic        stall, mis, err;

  logic        rd2, wr2;
  logic [2:0]  f3_2;
  logic [31:0] addr2, wd2;
  logic [31:0] rdata_m2;
  logic        stall2, mis2, err2;

  int ncomp = 0;
  int nfail = 0;

  mem_access_unit_if bus ();
  mem_access_unit_if bus2 ();

  mem_access_unit dut (
    .clk(clk), .reset(reset), .MemRead_M(rd), .MemWrite_M(wr), .Funct3_M(f3),
    .MemAddr_M(addr), .MemWriteData_M(wd), .MemReadData_M(rdata_m),
    .stall_M(stall), .misalign_M(mis), .bus_err_M(err), .dbus(bus)
  );

  mem_access_unit #(.WAIT_LIMIT(4)) dut2 (
    .clk(clk), .reset(reset), .MemRead_M(rd2), .MemWrite_M(wr2), .Funct3_M(f3_2),
    .MemAddr_M(addr2), .MemWriteData_M(wd2), .MemReadData_M(rdata_m2),
    .stall_M(stall2), .misalign_M(mis2), .bus_err_M(err2), .dbus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load with gnt in the issue cycle and rvalid one cycle later.
  task automatic run_load(input string tag, input logic [2:0] fc, input logic [31:0] a,
                          input logic [31:0] word, input logic [31:0] exp);
    step();
    rd = 1'b1; wr = 1'b0; f3 = fc; addr = a; bus.dbus_gnt = 1'b1; bus.dbus_rvalid = 1'b0;
    #1;
    chk({tag, "_req"}, {31'b0, bus.dbus_req}, 32'd1);
    chk({tag, "_stall_idle"}, {31'b0, stall}, 32'd1);
    chk({tag, "_addr"}, bus.dbus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'b0, bus.dbus_be}, 32'hF);
    step();
    bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b1; bus.dbus_rdata = word;
    #1;
    chk({tag, "_stall_wait"}, {31'b0, stall}, 32'd1);
    step();
    bus.dbus_rvalid = 1'b0; bus.dbus_rdata = 32'h0BAD_F00D;
    #1;
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_data"}, rdata_m, exp);
  endtask

  // Store with immediate gnt and ack one cycle later.
  task automatic run_store(input string tag, input logic [2:0] fc, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    step();
    rd = 1'b0; wr = 1'b1; f3 = fc; addr = a; wd = d; bus.dbus_gnt = 1'b1;
    #1;
    chk({tag, "_be"}, {28'b0, bus.dbus_be}, {28'b0, exp_be});
    chk({tag, "_wdata"}, bus.dbus_wdata, exp_wd);
    chk({tag, "_we"}, {31'b0, bus.dbus_we}, 32'd1);
    step();
    bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b1;
    step();
    bus.dbus_rvalid = 1'b0;
    #1;
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_data"}, rdata_m, 32'h0);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    reset = 1'b1;
    rd = 0; wr = 0; f3 = F3_W; addr = 0; wd = 0;
    rd2 = 0; wr2 = 0; f3_2 = F3_W; addr2 = 32'h300; wd2 = 0;
    bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_rdata = 0;
    bus2.dbus_gnt = 0; bus2.dbus_rvalid = 0; bus2.dbus_rdata = 0;
    step();
    step();
    chk("rst_req", {31'b0, bus.dbus_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_data", rdata_m, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;

    run_load("lw100", F3_W, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("lb103", F3_B, 32'h103, 32'h80112233, 32'hFFFFFF80);
    run_load("lbu103", F3_BU, 32'h103, 32'h80112233, 32'h00000080);
    run_load("lh102", F3_H, 32'h102, 32'h80112233, 32'hFFFF8011);
    run_load("lhu100", F3_HU, 32'h100, 32'h80112233, 32'h00002233);
    step();
    rd = 1'b0;
    #1;
    chk("idle_after_done_data", rdata_m, 32'h0);

    // SB with gnt arriving on the fourth request cycle.
    step();
    wr = 1'b1; f3 = F3_B; addr = 32'h201; wd = 32'h000000AB; bus.dbus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dbus_gnt = 1'b1;
      #1;
      chk("sb_req", {31'b0, bus.dbus_req}, 32'd1);
      chk("sb_addr", bus.dbus_addr, 32'h200);
      chk("sb_be", {28'b0, bus.dbus_be}, 32'b0010);
      chk("sb_wdata", bus.dbus_wdata, 32'hABABABAB);
      chk("sb_we", {31'b0, bus.dbus_we}, 32'd1);
      chk("sb_stall", {31'b0, stall}, 32'd1);
      step();
    end
    bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b1;
    #1;
    chk("sb_wait_req", {31'b0, bus.dbus_req}, 32'd0);
    chk("sb_wait_stall", {31'b0, stall}, 32'd1);
    step();
    bus.dbus_rvalid = 1'b0;
    #1;
    chk("sb_done_stall", {31'b0, stall}, 32'd0);

    run_store("sh202", F3_H, 32'h202, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    run_store("sw204", F3_W, 32'h204, 32'h11223344, 4'b1111, 32'h11223344);

    // Misaligned accesses are suppressed.
    step();
    wr = 1'b0; rd = 1'b1; f3 = F3_W; addr = 32'h102;
    #1;
    chk("mis_lw_flag", {31'b0, mis}, 32'd1);
    chk("mis_lw_req", {31'b0, bus.dbus_req}, 32'd0);
    chk("mis_lw_stall", {31'b0, stall}, 32'd0);
    chk("mis_lw_data", rdata_m, 32'h0);
    step();
    rd = 1'b0; wr = 1'b1; f3 = F3_H; addr = 32'h203;
    #1;
    chk("mis_sh_flag", {31'b0, mis}, 32'd1);
    chk("mis_sh_req", {31'b0, bus.dbus_req}, 32'd0);
    step();
    wr = 1'b0;
    #1;
    chk("mis_clear", {31'b0, mis}, 32'd0);

    // Reset asserted while waiting for rvalid.
    step();
    rd = 1'b1; f3 = F3_W; addr = 32'h400; bus.dbus_gnt = 1'b1;
    step();
    bus.dbus_gnt = 1'b0;
    #1;
    chk("rstw_stall_before", {31'b0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_req", {31'b0, bus.dbus_req}, 32'd0);
    chk("rstw_stall", {31'b0, stall}, 32'd0);
    step();
    reset = 1'b0; rd = 1'b0;
    run_load("lw_after_rst", F3_W, 32'h404, 32'hCAFEF00D, 32'hCAFEF00D);
    step();
    rd = 1'b0;

    // Timeout on the WAIT_LIMIT=4 instance: DONE is reached 5 edges after issue.
    rd2 = 1'b1; bus2.dbus_gnt = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      bus2.dbus_gnt = 1'b0;
      if (err2) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at = i;
          chk("to_data", rdata_m2, 32'h0);
          chk("to_stall", {31'b0, stall2}, 32'd0);
          chk("to_req", {31'b0, bus2.dbus_req}, 32'd0);
          rd2 = 1'b0;
        end
      end
    end
    chk("to_pulse_count", pulses, 32'd1);
    chk("to_pulse_cycle", pulse_at, 32'd5);
    chk("to_idle_stall", {31'b0, stall2}, 32'd0);

    // rvalid in the same cycle as the timeout: data kept, no error.
    step();
    rd2 = 1'b1; bus2.dbus_gnt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      bus2.dbus_gnt = 1'b0;
      if (i == 1) rd2 = 1'b1;
    end
    bus2.dbus_rvalid = 1'b1; bus2.dbus_rdata = 32'h12345678;
    step();
    bus2.dbus_rvalid = 1'b0; rd2 = 1'b0;
    #1;
    chk("race_err", {31'b0, err2}, 32'd0);
    chk("race_data", rdata_m2, 32'h12345678);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
